uart_reg_bridge: RTL and testbench

Byte-stream command decoder between the UART receiver/transmitter pair and the register file. Parses framed write/read commands from the RX byte stream and issues single-cycle register write/read strobes with address and data. Returns read data, and optionally a write acknowledge, to the UART transmitter over a valid/ready handshake. Also aborts stalled frames on an inter-byte timeout.

---
 rtl/uart_reg_bridge.sv | 173 +++++++++++++++++
 tb/tb_uart_reg_bridge.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_reg_bridge.sv
// uart_reg_bridge: decodes 'W' addr data / 'R' addr frames from a UART byte
// stream into register strobes and returns read data or a write ACK over TX.
module uart_reg_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    parameter bit          ACK_EN         = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_valid_i,
    input  logic [7:0] rx_data_i,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    input  logic       tx_ready_i,
    output logic       reg_wr_o,
    output logic       reg_rd_o,
    output logic [7:0] reg_addr_o,
    output logic [7:0] reg_data_o,
    input  logic [7:0] reg_data_i,
    output logic       frame_err_o,
    output logic       busy_o
);

    localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  CMD_WR   = 8'h57;
    localparam logic [7:0]  CMD_RD   = 8'h52;
    localparam logic [7:0]  ACK_BYTE = 8'h06;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_READ  = 3'd4,
        S_TX    = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic               op_wr_q, op_wr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               tx_valid_q, tx_valid_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               reg_wr_q, reg_wr_d;
    logic               reg_rd_q, reg_rd_d;
    logic [7:0]         reg_addr_q, reg_addr_d;
    logic [7:0]         reg_data_q, reg_data_d;
    logic               frame_err_q, frame_err_d;
    logic               busy_q, busy_d;

    // Next-state and next-output decode; strobes and error default low each cycle
    always_comb begin
        state_d     = state_q;
        op_wr_d     = op_wr_q;
        cnt_d       = cnt_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        reg_wr_d    = 1'b0;
        reg_rd_d    = 1'b0;
        reg_addr_d  = reg_addr_q;
        reg_data_d  = reg_data_q;
        frame_err_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    if (rx_data_i == CMD_WR) begin
                        state_d = S_ADDR;
                        op_wr_d = 1'b1;
                        cnt_d   = '0;
                    end else if (rx_data_i == CMD_RD) begin
                        state_d = S_ADDR;
                        op_wr_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end
            S_ADDR, S_DATA: begin
                if (rx_valid_i) begin
                    cnt_d = '0;
                    if (state_q == S_DATA) begin
                        reg_data_d = rx_data_i;
                        reg_wr_d   = 1'b1;
                        state_d    = S_WRITE;
                    end else begin
                        reg_addr_d = rx_data_i;
                        if (op_wr_q) begin
                            state_d = S_DATA;
                        end else begin
                            reg_rd_d = 1'b1;
                            state_d  = S_READ;
                        end
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    // Stalled frame: abandon it and report
                    cnt_d       = '0;
                    frame_err_d = 1'b1;
                    state_d     = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WRITE: begin
                frame_err_d = rx_valid_i;
                if (ACK_EN) begin
                    tx_valid_d = 1'b1;
                    tx_data_d  = ACK_BYTE;
                    state_d    = S_TX;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_READ: begin
                frame_err_d = rx_valid_i;
                tx_valid_d  = 1'b1;
                tx_data_d   = reg_data_i;
                state_d     = S_TX;
            end
            S_TX: begin
                frame_err_d = rx_valid_i;
                if (tx_ready_i) begin
                    tx_valid_d = 1'b0;
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // All state and output flops; reset wins over any in-flight frame
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_wr_q     <= 1'b0;
            cnt_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            reg_wr_q    <= 1'b0;
            reg_rd_q    <= 1'b0;
            reg_addr_q  <= 8'h00;
            reg_data_q  <= 8'h00;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_wr_q     <= op_wr_d;
            cnt_q       <= cnt_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            reg_wr_q    <= reg_wr_d;
            reg_rd_q    <= reg_rd_d;
            reg_addr_q  <= reg_addr_d;
            reg_data_q  <= reg_data_d;
            frame_err_q <= frame_err_d;
            busy_q      <= busy_d;
        end
    end

    assign tx_valid_o  = tx_valid_q;
    assign tx_data_o   = tx_data_q;
    assign reg_wr_o    = reg_wr_q;
    assign reg_rd_o    = reg_rd_q;
    assign reg_addr_o  = reg_addr_q;
    assign reg_data_o  = reg_data_q;
    assign frame_err_o = frame_err_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_reg_bridge.sv
// Testbench for uart_reg_bridge: per-cycle vector table plus hand sequences.
module tb_uart_reg_bridge;

    logic       clk;
    logic       rst_n;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       frame_err;
    logic       busy;

    // second instance, ACK disabled
    logic       rx_valid2;
    logic [7:0] rx_data2;
    logic       tx_valid2;
    logic [7:0] tx_data2;
    logic       reg_wr2;
    logic       reg_rd2;
    logic [7:0] reg_addr2;
    logic [7:0] reg_wdata2;
    logic       frame_err2;
    logic       busy2;

    int n_vec;
    int n_err;

    uart_reg_bridge #(.TIMEOUT_CYCLES(16), .ACK_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data),
        .tx_valid_o(tx_valid), .tx_data_o(tx_data), .tx_ready_i(tx_ready),
        .reg_wr_o(reg_wr), .reg_rd_o(reg_rd),
        .reg_addr_o(reg_addr), .reg_data_o(reg_wdata), .reg_data_i(reg_rdata),
        .frame_err_o(frame_err), .busy_o(busy)
    );

    uart_reg_bridge #(.TIMEOUT_CYCLES(16), .ACK_EN(1'b0)) dut_noack (
        .clk(clk), .rst_n(rst_n),
        .rx_valid_i(rx_valid2), .rx_data_i(rx_data2),
        .tx_valid_o(tx_valid2), .tx_data_o(tx_data2), .tx_ready_i(1'b0),
        .reg_wr_o(reg_wr2), .reg_rd_o(reg_rd2),
        .reg_addr_o(reg_addr2), .reg_data_o(reg_wdata2), .reg_data_i(8'h00),
        .frame_err_o(frame_err2), .busy_o(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic       rxv;
        logic [7:0] rxd;
        logic       txr;
        logic [7:0] rdi;
        logic       tv;
        logic [7:0] td;
        logic       wr;
        logic       rd;
        logic [7:0] addr;
        logic [7:0] data;
        logic       err;
        logic       busy;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic r, input logic v, input logic [7:0] d,
                       input logic txr, input logic [7:0] rdi,
                       input logic tv, input logic [7:0] td,
                       input logic wr, input logic rd,
                       input logic [7:0] addr, input logic [7:0] data,
                       input logic err, input logic bsy);
        vec_t e;
        e.rst_n = r;  e.rxv = v;   e.rxd = d;   e.txr = txr; e.rdi = rdi;
        e.tv = tv;    e.td = td;   e.wr = wr;   e.rd = rd;
        e.addr = addr; e.data = data; e.err = err; e.busy = bsy;
        vq.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0; reg_rdata = 8'h00;
        rx_valid2 = 1'b0; rx_data2 = 8'h00;

        // reset, idle
        add(0,0,8'h00,0,8'h00, 0,8'h00,0,0,8'h00,8'h00,0,0);
        add(1,0,8'h00,0,8'h00, 0,8'h00,0,0,8'h00,8'h00,0,0);
        // write 57 01 34, ACK held two cycles then accepted
        add(1,1,8'h57,0,8'h00, 0,8'h00,0,0,8'h00,8'h00,0,1);
        add(1,1,8'h01,0,8'h00, 0,8'h00,0,0,8'h01,8'h00,0,1);
        add(1,1,8'h34,0,8'h00, 0,8'h00,1,0,8'h01,8'h34,0,1);
        add(1,0,8'h00,0,8'h00, 1,8'h06,0,0,8'h01,8'h34,0,1);
        add(1,0,8'h00,0,8'h00, 1,8'h06,0,0,8'h01,8'h34,0,1);
        add(1,0,8'h00,1,8'h00, 0,8'h06,0,0,8'h01,8'h34,0,0);
        // read 52 02 -> A5, ready withheld 10 cycles, stray byte mid-stall
        add(1,1,8'h52,0,8'h00, 0,8'h06,0,0,8'h01,8'h34,0,1);
        add(1,1,8'h02,0,8'h00, 0,8'h06,0,1,8'h02,8'h34,0,1);
        add(1,0,8'h00,0,8'hA5, 1,8'hA5,0,0,8'h02,8'h34,0,1);
        for (int i = 0; i < 4; i++)
            add(1,0,8'h00,0,8'h3C, 1,8'hA5,0,0,8'h02,8'h34,0,1);
        add(1,1,8'h57,0,8'h3C, 1,8'hA5,0,0,8'h02,8'h34,1,1);
        for (int i = 0; i < 5; i++)
            add(1,0,8'h00,0,8'h3C, 1,8'hA5,0,0,8'h02,8'h34,0,1);
        add(1,0,8'h00,1,8'h3C, 0,8'hA5,0,0,8'h02,8'h34,0,0);
        // bad command, then read of addr 0x57 returning 0x00, ready in first cycle
        add(1,1,8'h11,0,8'h00, 0,8'hA5,0,0,8'h02,8'h34,1,0);
        add(1,1,8'h52,0,8'h00, 0,8'hA5,0,0,8'h02,8'h34,0,1);
        add(1,1,8'h57,0,8'h00, 0,8'hA5,0,1,8'h57,8'h34,0,1);
        add(1,0,8'h00,0,8'h00, 1,8'h00,0,0,8'h57,8'h34,0,1);
        add(1,0,8'h00,1,8'h00, 0,8'h00,0,0,8'h57,8'h34,0,0);
        // back-to-back write with command bytes as payload
        add(1,1,8'h57,0,8'h00, 0,8'h00,0,0,8'h57,8'h34,0,1);
        add(1,1,8'hFF,0,8'h00, 0,8'h00,0,0,8'hFF,8'h34,0,1);
        add(1,1,8'h52,0,8'h00, 0,8'h00,1,0,8'hFF,8'h52,0,1);
        add(1,0,8'h00,1,8'h00, 1,8'h06,0,0,8'hFF,8'h52,0,1);
        add(1,0,8'h00,1,8'h00, 0,8'h06,0,0,8'hFF,8'h52,0,0);
        // reset between addr and data, then a fresh write
        add(1,1,8'h57,0,8'h00, 0,8'h06,0,0,8'hFF,8'h52,0,1);
        add(1,1,8'h10,0,8'h00, 0,8'h06,0,0,8'h10,8'h52,0,1);
        add(0,1,8'h99,0,8'h00, 0,8'h00,0,0,8'h00,8'h00,0,0);
        add(1,0,8'h00,0,8'h00, 0,8'h00,0,0,8'h00,8'h00,0,0);
        add(1,1,8'h57,0,8'h00, 0,8'h00,0,0,8'h00,8'h00,0,1);
        add(1,1,8'h05,0,8'h00, 0,8'h00,0,0,8'h05,8'h00,0,1);
        add(1,1,8'h06,0,8'h00, 0,8'h00,1,0,8'h05,8'h06,0,1);
        add(1,0,8'h00,0,8'h00, 1,8'h06,0,0,8'h05,8'h06,0,1);
        add(1,0,8'h00,1,8'h00, 0,8'h06,0,0,8'h05,8'h06,0,0);
        // timeout in DATA after 16 silent cycles
        add(1,1,8'h57,0,8'h00, 0,8'h06,0,0,8'h05,8'h06,0,1);
        add(1,1,8'h03,0,8'h00, 0,8'h06,0,0,8'h03,8'h06,0,1);
        for (int i = 0; i < 15; i++)
            add(1,0,8'h00,0,8'h00, 0,8'h06,0,0,8'h03,8'h06,0,1);
        add(1,0,8'h00,0,8'h00, 0,8'h06,0,0,8'h03,8'h06,1,0);
        add(1,0,8'h00,0,8'h00, 0,8'h06,0,0,8'h03,8'h06,0,0);
        // retry the write; stray byte during WRITE flags an error only
        add(1,1,8'h57,0,8'h00, 0,8'h06,0,0,8'h03,8'h06,0,1);
        add(1,1,8'h03,0,8'h00, 0,8'h06,0,0,8'h03,8'h06,0,1);
        add(1,1,8'h7F,0,8'h00, 0,8'h06,1,0,8'h03,8'h7F,0,1);
        add(1,1,8'h44,1,8'h00, 1,8'h06,0,0,8'h03,8'h7F,1,1);
        add(1,0,8'h00,1,8'h00, 0,8'h06,0,0,8'h03,8'h7F,0,0);

        #1;
        foreach (vq[i]) begin
            rst_n     = vq[i].rst_n;
            rx_valid  = vq[i].rxv;
            rx_data   = vq[i].rxd;
            tx_ready  = vq[i].txr;
            reg_rdata = vq[i].rdi;
            tick();
            n_vec++;
            if ({tx_valid, tx_data, reg_wr, reg_rd, reg_addr, reg_wdata, frame_err, busy} !==
                {vq[i].tv, vq[i].td, vq[i].wr, vq[i].rd, vq[i].addr, vq[i].data, vq[i].err, vq[i].busy}) begin
                n_err++;
                $display("FAIL vec%0d: got tv=%b td=%h wr=%b rd=%b a=%h d=%h err=%b busy=%b, expected tv=%b td=%h wr=%b rd=%b a=%h d=%h err=%b busy=%b",
                         i, tx_valid, tx_data, reg_wr, reg_rd, reg_addr, reg_wdata, frame_err, busy,
                         vq[i].tv, vq[i].td, vq[i].wr, vq[i].rd, vq[i].addr, vq[i].data, vq[i].err, vq[i].busy);
            end
        end
        rx_valid = 1'b0; tx_ready = 1'b0; rst_n = 1'b1;

        // read of 0x80 with bounded waits on strobe and TX valid
        begin
            int n;
            rx_valid = 1'b1; rx_data = 8'h52; tick();
            rx_data = 8'h80; tick();
            rx_valid = 1'b0; reg_rdata = 8'h5A;
            n = 0;
            while (!reg_rd && n < 4) begin tick(); n++; end
            chk("rd_strobe_seen", 32'(reg_rd), 32'd1);
            chk("rd_addr", 32'(reg_addr), 32'h80);
            n = 0;
            tick();
            while (!tx_valid && n < 4) begin tick(); n++; end
            chk("rd_tx_valid", 32'(tx_valid), 32'd1);
            chk("rd_tx_data", 32'(tx_data), 32'h5A);
            tx_ready = 1'b1; tick(); tx_ready = 1'b0;
            chk("rd_done", 32'({tx_valid, busy}), 32'd0);
        end

        // ACK disabled: write strobes but never raises TX valid
        rx_valid2 = 1'b1; rx_data2 = 8'h57; tick();
        rx_data2 = 8'h0A; tick();
        rx_data2 = 8'h5C; tick();
        rx_valid2 = 1'b0;
        chk("noack_write", 32'({reg_wr2, reg_addr2, reg_wdata2}), 32'({1'b1, 8'h0A, 8'h5C}));
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("noack_idle", 32'({tx_valid2, busy2, reg_wr2, frame_err2}), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
